// File: rtl/debug_pkg.sv
// Shared encodings for the pipeline debug sequencer: FSM state codes,
// host command bytes and the register dump size.
package debug_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD_LEN  = 3'd1,
        ST_LOAD_WORD = 3'd2,
        ST_RUN       = 3'd3,
        ST_STEP      = 3'd4,
        ST_DRAIN     = 3'd5,
        ST_DUMP      = 3'd6
    } state_t;

    // Sub-phases of one dumped word: address out, sample + start serializer, wait done
    typedef enum logic [1:0] {
        DP_ADDR  = 2'd0,
        DP_START = 2'd1,
        DP_WAIT  = 2'd2
    } dump_phase_t;

    localparam logic [7:0] CMD_LOAD  = 8'h4C;
    localparam logic [7:0] CMD_CONT  = 8'h43;
    localparam logic [7:0] CMD_STEP  = 8'h53;
    localparam logic [7:0] CMD_DUMP  = 8'h44;
    localparam logic [7:0] CMD_RESET = 8'h52;
    localparam logic [7:0] CMD_HALT  = 8'h48;

    localparam int unsigned DUMP_REG_WORDS = 32;

endpackage

// File: rtl/debug_word_tx.sv
// Word-to-byte serializer, MSB first, on a valid/ready byte channel.
// o_done pulses one cycle after the last byte is accepted.
module debug_word_tx #(
    parameter int unsigned NB_DATA = 32
) (
    input  logic               clk,
    input  logic               i_rst_n,
    input  logic               i_start,
    input  logic [NB_DATA-1:0] i_word,
    input  logic               i_tx_ready,
    output logic [7:0]         o_tx_data,
    output logic               o_tx_valid,
    output logic               o_done
);
    localparam int unsigned NB_BYTES = NB_DATA / 8;
    localparam int unsigned NB_BCNT  = $clog2(NB_BYTES);

    logic [NB_DATA-1:0] r_word;
    logic [NB_BCNT-1:0] r_cnt;
    logic               r_valid;
    logic               r_done;
    logic               w_accept;
    logic               w_last;

    assign w_accept = r_valid && i_tx_ready;
    assign w_last   = (r_cnt == NB_BCNT'(NB_BYTES - 1));

    // Top byte of r_word is always the byte on the channel; it only moves on acceptance
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_word  <= '0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_start && !r_valid) begin
                r_word  <= i_word;
                r_cnt   <= '0;
                r_valid <= 1'b1;
            end else if (w_accept) begin
                if (w_last) begin
                    r_valid <= 1'b0;
                    r_done  <= 1'b1;
                end else begin
                    r_word <= {r_word[NB_DATA-9:0], 8'h00};
                    r_cnt  <= r_cnt + NB_BCNT'(1);
                end
            end
        end
    end

    assign o_tx_data  = r_word[NB_DATA-1 -: 8];
    assign o_tx_valid = r_valid;
    assign o_done     = r_done;

endmodule

// File: rtl/pipeline_debug_ctrl.sv
// Host-driven debug sequencer for the five-stage pipeline: program load, run/step/halt,
// drain and register dump. Define DEBUG_PC_DUMP_EN to append the PC word to each dump.
module pipeline_debug_ctrl
    import debug_pkg::*;
#(
    parameter int unsigned NB_DATA      = 32,
    parameter int unsigned NB_IMEM_ADDR = 8,
    parameter int unsigned NB_REG_ADDR  = 5,
    parameter int unsigned DRAIN_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    i_rst_n,
    input  logic [7:0]              i_rx_data,
    input  logic                    i_rx_valid,
    output logic [7:0]              o_tx_data,
    output logic                    o_tx_valid,
    input  logic                    i_tx_ready,
    output logic                    o_imem_we,
    output logic [NB_IMEM_ADDR-1:0] o_imem_addr,
    output logic [NB_DATA-1:0]      o_imem_data,
    output logic                    o_run_en,
    output logic                    o_pipe_clr,
    input  logic                    i_stop,
    input  logic [NB_DATA-1:0]      i_pc,
    output logic [NB_REG_ADDR-1:0]  o_dbg_reg_addr,
    input  logic [NB_DATA-1:0]      i_dbg_reg_data,
    output logic [2:0]              o_state
);
    localparam int unsigned NB_BYTES = NB_DATA / 8;
    localparam int unsigned NB_BCNT  = $clog2(NB_BYTES);
    localparam int unsigned NB_SHIFT = NB_DATA - 8;
    localparam int unsigned NB_DRAIN = $clog2(DRAIN_CYCLES + 1);

    state_t                  r_state,      w_state_nxt;
    dump_phase_t             r_phase,      w_phase_nxt;
    logic [7:0]              r_words_left, w_words_left_nxt;
    logic [NB_BCNT-1:0]      r_byte_cnt,   w_byte_cnt_nxt;
    logic [NB_SHIFT-1:0]     r_shift,      w_shift_nxt;
    logic [NB_DRAIN-1:0]     r_drain_cnt,  w_drain_cnt_nxt;
    logic                    r_imem_we,    w_imem_we_nxt;
    logic [NB_IMEM_ADDR-1:0] r_imem_addr,  w_imem_addr_nxt;
    logic [NB_DATA-1:0]      r_imem_data,  w_imem_data_nxt;
    logic                    r_run_en,     w_run_en_nxt;
    logic                    r_pipe_clr,   w_pipe_clr_nxt;
    logic [NB_REG_ADDR-1:0]  r_reg_addr,   w_reg_addr_nxt;
    logic                    w_tx_start;
    logic [NB_DATA-1:0]      w_tx_word;
    logic                    w_tx_done;
    logic                    w_last_reg;

`ifdef DEBUG_PC_DUMP_EN
    logic [NB_DATA-1:0]      r_pc,         w_pc_nxt;
    logic                    r_dump_pc,    w_dump_pc_nxt;
    assign w_tx_word = r_dump_pc ? r_pc : i_dbg_reg_data;
`else
    logic                    w_unused_pc;
    assign w_unused_pc = ^i_pc;
    assign w_tx_word   = i_dbg_reg_data;
`endif

    assign w_last_reg = (r_reg_addr == NB_REG_ADDR'(DUMP_REG_WORDS - 1));

    debug_word_tx #(.NB_DATA(NB_DATA)) u_word_tx (
        .clk        (clk),
        .i_rst_n    (i_rst_n),
        .i_start    (w_tx_start),
        .i_word     (w_tx_word),
        .i_tx_ready (i_tx_ready),
        .o_tx_data  (o_tx_data),
        .o_tx_valid (o_tx_valid),
        .o_done     (w_tx_done)
    );

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt      = r_state;
        w_phase_nxt      = r_phase;
        w_words_left_nxt = r_words_left;
        w_byte_cnt_nxt   = r_byte_cnt;
        w_shift_nxt      = r_shift;
        w_drain_cnt_nxt  = r_drain_cnt;
        w_imem_we_nxt    = 1'b0;
        w_imem_data_nxt  = r_imem_data;
        w_pipe_clr_nxt   = 1'b0;
        w_reg_addr_nxt   = r_reg_addr;
        w_tx_start       = 1'b0;
`ifdef DEBUG_PC_DUMP_EN
        w_pc_nxt         = r_pc;
        w_dump_pc_nxt    = r_dump_pc;
`endif
        // Write address advances the cycle after each write strobe
        w_imem_addr_nxt  = r_imem_we ? r_imem_addr + NB_IMEM_ADDR'(1) : r_imem_addr;

        case (r_state)
            ST_IDLE: begin
                if (i_rx_valid) begin
                    case (i_rx_data)
                        CMD_LOAD:  w_state_nxt    = ST_LOAD_LEN;
                        CMD_CONT:  w_state_nxt    = ST_RUN;
                        CMD_STEP:  w_state_nxt    = ST_STEP;
                        CMD_DUMP:  w_state_nxt    = ST_DUMP;
                        CMD_RESET: w_pipe_clr_nxt = 1'b1;
                        default:   ;
                    endcase
                end
            end
            ST_LOAD_LEN: begin
                if (i_rx_valid) begin
                    if (i_rx_data == 8'h00) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_words_left_nxt = i_rx_data;
                        w_byte_cnt_nxt   = '0;
                        w_imem_addr_nxt  = '0;
                        w_state_nxt      = ST_LOAD_WORD;
                    end
                end
            end
            ST_LOAD_WORD: begin
                if (i_rx_valid) begin
                    if (r_byte_cnt == NB_BCNT'(NB_BYTES - 1)) begin
                        w_imem_we_nxt   = 1'b1;
                        w_imem_data_nxt = {r_shift, i_rx_data};
                        w_byte_cnt_nxt  = '0;
                        if (r_words_left == 8'd1) begin
                            w_state_nxt    = ST_IDLE;
                            w_pipe_clr_nxt = 1'b1;
                        end else begin
                            w_words_left_nxt = r_words_left - 8'd1;
                        end
                    end else begin
                        w_shift_nxt    = {r_shift[NB_SHIFT-9:0], i_rx_data};
                        w_byte_cnt_nxt = r_byte_cnt + NB_BCNT'(1);
                    end
                end
            end
            ST_RUN: begin
                if (i_stop || (i_rx_valid && (i_rx_data == CMD_HALT))) begin
                    w_state_nxt     = ST_DRAIN;
                    w_drain_cnt_nxt = '0;
                end
            end
            ST_STEP: w_state_nxt = ST_DUMP;
            ST_DRAIN: begin
                if (r_drain_cnt == NB_DRAIN'(DRAIN_CYCLES - 1)) begin
                    w_state_nxt = ST_DUMP;
                end else begin
                    w_drain_cnt_nxt = r_drain_cnt + NB_DRAIN'(1);
                end
            end
            ST_DUMP: begin
                case (r_phase)
                    DP_ADDR:  w_phase_nxt = DP_START;
                    DP_START: begin
                        w_tx_start  = 1'b1;
                        w_phase_nxt = DP_WAIT;
                    end
                    DP_WAIT: begin
                        if (w_tx_done) begin
`ifdef DEBUG_PC_DUMP_EN
                            if (r_dump_pc) begin
                                w_state_nxt = ST_IDLE;
                            end else if (w_last_reg) begin
                                w_dump_pc_nxt = 1'b1;
                                w_phase_nxt   = DP_START;
                            end else begin
`else
                            if (w_last_reg) begin
                                w_state_nxt = ST_IDLE;
                            end else begin
`endif
                                w_reg_addr_nxt = r_reg_addr + NB_REG_ADDR'(1);
                                w_phase_nxt    = DP_ADDR;
                            end
                        end
                    end
                    default: w_phase_nxt = DP_ADDR;
                endcase
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        // Every entry into the dump restarts it from r0
        if ((w_state_nxt == ST_DUMP) && (r_state != ST_DUMP)) begin
            w_reg_addr_nxt = '0;
            w_phase_nxt    = DP_ADDR;
`ifdef DEBUG_PC_DUMP_EN
            w_pc_nxt       = i_pc;
            w_dump_pc_nxt  = 1'b0;
`endif
        end

        w_run_en_nxt = (w_state_nxt == ST_RUN) || (w_state_nxt == ST_STEP) ||
                       (w_state_nxt == ST_DRAIN);
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= ST_IDLE;
            r_phase      <= DP_ADDR;
            r_words_left <= '0;
            r_byte_cnt   <= '0;
            r_shift      <= '0;
            r_drain_cnt  <= '0;
            r_imem_we    <= 1'b0;
            r_imem_addr  <= '0;
            r_imem_data  <= '0;
            r_run_en     <= 1'b0;
            r_pipe_clr   <= 1'b0;
            r_reg_addr   <= '0;
`ifdef DEBUG_PC_DUMP_EN
            r_pc         <= '0;
            r_dump_pc    <= 1'b0;
`endif
        end else begin
            r_state      <= w_state_nxt;
            r_phase      <= w_phase_nxt;
            r_words_left <= w_words_left_nxt;
            r_byte_cnt   <= w_byte_cnt_nxt;
            r_shift      <= w_shift_nxt;
            r_drain_cnt  <= w_drain_cnt_nxt;
            r_imem_we    <= w_imem_we_nxt;
            r_imem_addr  <= w_imem_addr_nxt;
            r_imem_data  <= w_imem_data_nxt;
            r_run_en     <= w_run_en_nxt;
            r_pipe_clr   <= w_pipe_clr_nxt;
            r_reg_addr   <= w_reg_addr_nxt;
`ifdef DEBUG_PC_DUMP_EN
            r_pc         <= w_pc_nxt;
            r_dump_pc    <= w_dump_pc_nxt;
`endif
        end
    end

    assign o_imem_we      = r_imem_we;
    assign o_imem_addr    = r_imem_addr;
    assign o_imem_data    = r_imem_data;
    assign o_run_en       = r_run_en;
    assign o_pipe_clr     = r_pipe_clr;
    assign o_dbg_reg_addr = r_reg_addr;
    assign o_state        = r_state;

endmodule

// File: doc/pipeline_debug_ctrl.md
# pipeline_debug_ctrl

Debug sequencer for the five-stage MIPS pipeline. It decodes byte commands from the UART receiver to load programs into instruction memory, run the pipeline continuously or one cycle at a time, and stop it on the HALT instruction or on a host command. After every stop it drains the pipeline and streams the register file and PC back to the host through the UART transmitter.

## Interface
Parameters:
- NB_DATA, 32, datapath and instruction word width
- NB_IMEM_ADDR, 8, instruction-memory word-address width
- NB_REG_ADDR, 5, register-file address width
- DRAIN_CYCLES, 4, cycles the pipeline keeps running after a stop request

Ports:
- clk  in  1  single clock, rising edge
- i_rst_n  in  1  asynchronous, active-low reset
- i_rx_data  in  8  received byte
- i_rx_valid  in  1  one-cycle strobe, no backpressure
- o_tx_data  out  8  byte to transmit
- o_tx_valid  out  1  byte valid, held until accepted
- i_tx_ready  in  1  transmitter accepts when valid&&ready
- o_imem_we  out  1  instruction-memory write strobe
- o_imem_addr  out  NB_IMEM_ADDR  word address
- o_imem_data  out  NB_DATA  instruction word
- o_run_en  out  1  pipeline advance enable (inverse drives pipeline halt)
- o_pipe_clr  out  1  one-cycle pipeline/PC clear pulse
- i_stop  in  1  HALT detected in decode
- i_pc  in  NB_DATA  current PC
- o_dbg_reg_addr  out  NB_REG_ADDR  debug read address into register file
- i_dbg_reg_data  in  NB_DATA  debug read data
- o_state  out  3  current FSM state code

## Operation
- Commands: 0x4C 'L' load, 0x43 'C' continuous, 0x53 'S' step, 0x44 'D' dump, 0x52 'R' reset pipeline, 0x48 'H' halt. Unknown bytes are ignored in IDLE.
- States: IDLE(0), LOAD_LEN(1), LOAD_WORD(2), RUN(3), STEP(4), DRAIN(5), DUMP(6).
- IDLE: 'L'->LOAD_LEN; 'C'->RUN; 'S'->STEP; 'D'->DUMP; 'R'->o_pipe_clr pulse, stay IDLE.
- LOAD_LEN: the next byte N gives the word count. N=0 returns to IDLE with no writes. Otherwise the address resets to 0 and the FSM goes to LOAD_WORD.
- LOAD_WORD: assemble 4 bytes MSB first. After the 4th byte, o_imem_we is high one cycle with the word and the current address, then the address increments (wraps mod 2^NB_IMEM_ADDR). After N words, o_pipe_clr pulses and the FSM goes to IDLE.
- RUN: o_run_en=1. i_stop or an 'H' byte -> DRAIN. Simultaneous i_stop and 'H' cause a single drain. Other bytes are ignored.
- STEP: o_run_en=1 for exactly one cycle, then DUMP.
- DRAIN: o_run_en=1 for DRAIN_CYCLES cycles, then 0, then DUMP.
- DUMP: for r=0..31, drive o_dbg_reg_addr=r, sample i_dbg_reg_data the following cycle, and send 4 bytes MSB first. Then send PC (see Configuration). Return to IDLE after the last byte is accepted.
- Bytes received in STEP, DRAIN and DUMP are discarded.

## Timing
- Reset values: state IDLE; o_run_en, o_imem_we, o_pipe_clr, o_tx_valid =0; o_imem_addr, o_imem_data, o_tx_data, o_dbg_reg_addr =0; o_state=0.
- All outputs are registered.
- o_imem_we asserts the cycle after the 4th byte's i_rx_valid.
- tx handshake: o_tx_valid stays high and o_tx_data stays stable until i_tx_ready. The next byte may be presented the cycle after acceptance.
- Register read latency is one cycle from the address change to the sample.
- Reset mid-operation aborts immediately to IDLE. A partial word is not written and a partial dump is not resumed.
- o_run_en total high cycles: step = 1; stop = cycles in RUN + DRAIN_CYCLES.

## Configuration
- DEBUG_PC_DUMP_EN defined: the dump appends i_pc (sampled on entering DUMP) after r31, for 132 bytes total.
- DEBUG_PC_DUMP_EN undefined: the dump ends after r31, for 128 bytes total.

## Structure
- Shared package debug_pkg holds:
  - the state encoding constants
  - the command byte constants
  - the dump word count
- Sub-module debug_word_tx is a word-to-byte serializer with the valid/ready handshake and a done pulse. It is used for both register and PC words.

## Test plan
- Load: 'L', 0x02, bytes 20 01 00 05, FF FF FF FF -> imem[0]=0x20010005, imem[1]=0xFFFFFFFF, then one o_pipe_clr pulse and IDLE.
- Load with N=0: 'L', 0x00 -> no o_imem_we, state IDLE.
- Run to HALT: 'C', with i_stop asserted 10 cycles later -> o_run_en high for 10+4 cycles, then 128 bytes (132 with the macro), r0 bytes first.
- Step: 'S' -> o_run_en high exactly 1 cycle, then the dump.
- Backpressure: i_tx_ready toggles every 3 cycles during the dump -> no byte lost or duplicated, and o_tx_data is stable while valid.
- Reset mid-load: assert i_rst_n=0 after 2 bytes of a word -> all outputs 0, no write, and a subsequent 'L' works normally.
